// File: rtl/sprite_blob_pkg.sv
//------------------------------------------------------------------------------
// sprite_blob_pkg : shared screen geometry defaults and FSM state encoding
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sprite_blob_pkg;

    localparam int DEF_SCREEN_W = 1024;
    localparam int DEF_SCREEN_H = 768;

    // Position-update handshake states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_hit_test.sv
//------------------------------------------------------------------------------
// sprite_hit_test : combinational inside / outline test of a pixel vs sprite
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_hit_test
    import sprite_blob_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int MODE   = 0,
    parameter int BORDER = 2
) (
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    output logic        hit
);

    localparam logic [11:0] C_W12 = 12'(WIDTH);
    localparam logic [11:0] C_BX  = 12'(BORDER);
    localparam logic [10:0] C_H11 = 11'(HEIGHT);
    localparam logic [10:0] C_BY  = 11'(BORDER);

    // One extra bit so x+WIDTH near the right edge cannot wrap to a small value
    logic [11:0] w_hc, w_x0, w_x1;
    logic [10:0] w_vc, w_y0, w_y1;
    logic        w_in_x, w_in_y, w_edge_x, w_edge_y;

    assign w_hc = {1'b0, hcount};
    assign w_x0 = {1'b0, x};
    assign w_x1 = w_x0 + C_W12;
    assign w_vc = {1'b0, vcount};
    assign w_y0 = {1'b0, y};
    assign w_y1 = w_y0 + C_H11;

    assign w_in_x   = (w_hc >= w_x0) && (w_hc < w_x1);
    assign w_in_y   = (w_vc >= w_y0) && (w_vc < w_y1);
    assign w_edge_x = (w_hc < w_x0 + C_BX) || (w_hc + C_BX >= w_x1);
    assign w_edge_y = (w_vc < w_y0 + C_BY) || (w_vc + C_BY >= w_y1);

    generate
        if (MODE == 1) begin : g_outline
            assign hit = w_in_x && w_in_y && (w_edge_x || w_edge_y);
        end else begin : g_solid
            assign hit = w_in_x && w_in_y;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sprite_blob.sv
//------------------------------------------------------------------------------
// sprite_blob : rectangular sprite with handshake positioning and edge bounce
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_blob
    import sprite_blob_pkg::*;
#(
    parameter int          WIDTH    = 64,
    parameter int          HEIGHT   = 64,
    parameter logic [23:0] COLOR    = 24'hFF_FF_FF,
    parameter int          MODE     = 0,
    parameter int          BORDER   = 2,
    parameter int          SCREEN_W = DEF_SCREEN_W,
    parameter int          SCREEN_H = DEF_SCREEN_H,
    parameter int          INIT_X   = 0,
    parameter int          INIT_Y   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic [10:0] new_x,
    input  logic [9:0]  new_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic        auto_move,
    input  logic [3:0]  vel_x,
    input  logic [3:0]  vel_y,
    output logic [23:0] pixel,
    output logic        hit,
    output logic [10:0] x,
    output logic [9:0]  y
);

    localparam logic [11:0] C_MAX_X = 12'(SCREEN_W - WIDTH);
    localparam logic [10:0] C_MAX_Y = 11'(SCREEN_H - HEIGHT);

    state_t      state;
    logic [10:0] r_x, r_sx, w_nx, w_cx;
    logic [9:0]  r_y, r_sy, w_ny, w_cy;
    logic        r_dir_x, r_dir_y;      // 0 = positive, 1 = negative
    logic        w_ndx, w_ndy, w_hit;
    logic [11:0] w_x12, w_vx12;
    logic [10:0] w_y11, w_vy11;

    assign w_x12  = {1'b0, r_x};
    assign w_vx12 = {8'b0, vel_x};
    assign w_y11  = {1'b0, r_y};
    assign w_vy11 = {7'b0, vel_y};

    // Next auto-motion position with bounce; zero velocity leaves everything put
    always_comb begin
        w_nx  = r_x;
        w_ndx = r_dir_x;
        if (vel_x != 4'd0) begin
            if (!r_dir_x) begin
                if (w_x12 + w_vx12 > C_MAX_X) begin
                    w_nx  = C_MAX_X[10:0];
                    w_ndx = 1'b1;
                end else begin
                    w_nx = r_x + {7'b0, vel_x};
                end
            end else if (w_x12 < w_vx12) begin
                w_nx  = '0;
                w_ndx = 1'b0;
            end else begin
                w_nx = r_x - {7'b0, vel_x};
            end
        end
    end

    always_comb begin
        w_ny  = r_y;
        w_ndy = r_dir_y;
        if (vel_y != 4'd0) begin
            if (!r_dir_y) begin
                if (w_y11 + w_vy11 > C_MAX_Y) begin
                    w_ny  = C_MAX_Y[9:0];
                    w_ndy = 1'b1;
                end else begin
                    w_ny = r_y + {6'b0, vel_y};
                end
            end else if (w_y11 < w_vy11) begin
                w_ny  = '0;
                w_ndy = 1'b0;
            end else begin
                w_ny = r_y - {6'b0, vel_y};
            end
        end
    end

    assign w_cx = ({1'b0, r_sx} > C_MAX_X) ? C_MAX_X[10:0] : r_sx;
    assign w_cy = ({1'b0, r_sy} > C_MAX_Y) ? C_MAX_Y[9:0]  : r_sy;

    assign pos_ready = (state == ST_IDLE) && !reset;
    assign x = r_x;
    assign y = r_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            r_x     <= 11'(INIT_X);
            r_y     <= 10'(INIT_Y);
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start && auto_move) begin
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                        r_dir_x <= w_ndx;
                        r_dir_y <= w_ndy;
                    end
                    if (pos_valid) begin
                        r_sx  <= new_x;
                        r_sy  <= new_y;
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (frame_start) begin
                        r_x   <= w_cx;
                        r_y   <= w_cy;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sprite_hit_test #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .MODE   (MODE),
        .BORDER (BORDER)
    ) u_hit_test (
        .hcount (hcount),
        .vcount (vcount),
        .x      (r_x),
        .y      (r_y),
        .hit    (w_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel <= '0;
            hit   <= 1'b0;
        end else begin
            pixel <= w_hit ? COLOR : 24'h0;
            hit   <= w_hit;
        end
    end

endmodule

`default_nettype wire

// File: doc/sprite_blob.md
SPRITE_BLOB -- requirements
Module: sprite_blob

Interface
REQ-001 Parameter WIDTH, default 64, sprite width in pixels (1..1023).
REQ-002 Parameter HEIGHT, default 64, sprite height in lines (1..767).
REQ-003 Parameter COLOR, default 24'hFF_FF_FF, RGB fill colour.
REQ-004 Parameter MODE, default 0, 0 = solid fill, 1 = outline only.
REQ-005 Parameter BORDER, default 2, outline thickness in pixels (MODE 1 only).
REQ-006 Parameters SCREEN_W/SCREEN_H, defaults 1024/768, active display size.
REQ-007 Parameters INIT_X/INIT_Y, defaults 0/0, position after reset.
REQ-008 clock  in  1  system/pixel clock; single clock domain.
REQ-009 reset  in  1  asynchronous, active-high.
REQ-010 hcount  in  11  current pixel column.
REQ-011 vcount  in  10  current pixel line.
REQ-012 frame_start  in  1  one-cycle pulse, once per frame during blanking.
REQ-013 new_x / new_y  in  11 / 10  requested top-left position.
REQ-014 pos_valid / pos_ready  in / out  1 / 1  position-update handshake.
REQ-015 auto_move  in  1  enables per-frame motion with edge bounce.
REQ-016 vel_x / vel_y  in  4 / 4  unsigned speed in pixels per frame.
REQ-017 pixel  out  24  registered sprite colour, 0 outside sprite.
REQ-018 hit  out  1  registered, high when the pixel lies on the sprite.
REQ-019 x / y  out  11 / 10  current committed position.

Function
REQ-020 Position (x,y) SHALL change only on a cycle with frame_start=1.
REQ-021 FSM states IDLE and PEND; pos_ready = (state==IDLE) and not reset.
REQ-022 IDLE: pos_valid & pos_ready captures new_x/new_y into shadow registers, -> PEND.
REQ-023 PEND: frame_start commits the shadow position to x/y, -> IDLE; auto-motion is suppressed that frame.
REQ-024 IDLE with frame_start and auto_move=1: x advances by vel_x in direction dir_x, y by vel_y in direction dir_y.
REQ-025 Handshake and frame_start on the same IDLE cycle: auto-motion applies now; the captured position commits on the next frame_start.
REQ-026 Motion arithmetic in 12-bit (x) / 11-bit (y) unsigned; no wrap-around.
REQ-027 Right/bottom bounce: if next x > SCREEN_W-WIDTH, x = SCREEN_W-WIDTH and dir_x flips (same for y with HEIGHT).
REQ-028 Left/top bounce: if moving negative and x < vel_x, x = 0 and dir_x flips (same for y).
REQ-029 Committed new_x > SCREEN_W-WIDTH SHALL be clamped to SCREEN_W-WIDTH (same for y).
REQ-030 Inside test: x <= hcount < x+WIDTH and y <= vcount < y+HEIGHT, evaluated at 12/11-bit width.
REQ-031 MODE 1: hit only where inside and within BORDER of any sprite edge.
REQ-032 Latency 1: pixel/hit at cycle n+1 reflect hcount/vcount at cycle n.
REQ-033 pixel = COLOR when hit, else 24'h0.
REQ-034 vel=0 with auto_move=1 SHALL hold position and direction unchanged.

Reset
REQ-035 Reset SHALL asynchronously set x=INIT_X, y=INIT_Y, dir_x=dir_y=positive, state=IDLE, pixel=0, hit=0.
REQ-036 Reset mid-PEND SHALL discard the shadow position.

Structure
REQ-037 Screen dimensions and FSM state encodings SHALL live in a shared constants package/include.
REQ-038 Inside/outline test SHALL be a combinational sub-module sprite_hit_test; sequential logic stays in sprite_blob.

Verification
REQ-039 Reset, x=y=0, hcount=10, vcount=10 -> next cycle pixel=FFFFFF, hit=1; hcount=64 -> pixel=0.
REQ-040 pos_valid with new_x=100,new_y=50 -> pos_ready=0; x unchanged until frame_start, then x=100,y=50, pos_ready=1.
REQ-041 auto_move=1, vel_x=4, x=958, dir positive, frame_start -> x=960, dir_x negative; next frame_start -> x=956.
REQ-042 x=2, dir_x negative, vel_x=4, frame_start -> x=0, dir_x positive.
REQ-043 MODE=1, BORDER=2, x=y=0: (1,30) hit=1, (30,30) hit=0, (63,63) hit=1.
REQ-044 x=1000, WIDTH=64, hcount=5 -> hit=0 (no 11-bit overflow wrap).
